// File: rtl/inst_mem_scrubber.sv
`default_nettype none
// ============================================================================
// inst_mem_scrubber : background SECDED (39,32) scrubber for instruction memory
// Revision 1.0 - initial release
// ============================================================================
module inst_mem_scrubber #(
  parameter int WORDS          = 8,
  parameter int SCRUB_INTERVAL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scrub_en,
  input  logic        init_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        corrected,
  output logic        uncorrectable,
  output logic [31:0] err_addr,
  output logic [15:0] corr_count,
  output logic [15:0] uncorr_count
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] c_interval = CNT_W'(SCRUB_INTERVAL);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_FIX   = 2'd3
  } state_t;

  // Hamming code over positions 1..38; returns {p, c5..c0}
  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [5:0] c;
    int         k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < 6; i++)
          if (pos[i]) c[i] = c[i] ^ d[k[4:0]];
        k++;
      end
    end
    return {(^d) ^ (^c), c};
  endfunction

  function automatic logic [31:0] flip_mask(input logic [5:0] s);
    logic [31:0] m;
    int          k;
    m = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (pos[5:0] == s) m[k[4:0]] = 1'b1;
        k++;
      end
    end
    return m;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]       r_store [WORDS];
  logic [6:0]       w_new, w_fix_code, w_stored, w_store_wd;
  logic [5:0]       w_syn;
  logic             w_q, w_pow2;
  logic             w_store_we, w_corr, w_unc, w_err_set, w_we_nxt;
  logic [31:0]      w_wdata_nxt;

  assign mem_addr   = 32'({r_idx, 2'b00});
  assign w_new      = encode(mem_rdata);
  assign w_fix_code = encode(mem_wdata);
  assign w_stored   = r_store[r_idx];
  assign w_syn      = w_stored[5:0] ^ w_new[5:0];
  // Overall parity of the received codeword: live data plus stored check bits
  assign w_q        = w_stored[6] ^ (^mem_rdata) ^ (^w_stored[5:0]);
  assign w_pow2     = (w_syn != 6'd0) && ((w_syn & (w_syn - 6'd1)) == 6'd0);
  assign w_idx_inc  = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_store_we  = 1'b0;
    w_store_wd  = w_new;
    w_corr      = 1'b0;
    w_unc       = 1'b0;
    w_err_set   = 1'b0;
    w_we_nxt    = 1'b0;
    w_wdata_nxt = mem_wdata;
    case (r_state)
      S_INIT: begin
        w_store_we = 1'b1;
        if (r_idx == c_last_idx) begin
          w_state_nxt = S_WAIT;
          w_idx_nxt   = '0;
          w_cnt_nxt   = c_interval;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_WAIT: begin
        if (scrub_en) begin
          if (r_cnt <= CNT_W'(1)) w_state_nxt = S_CHECK;
          else                    w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_WAIT;
        w_idx_nxt   = w_idx_inc;
        w_cnt_nxt   = c_interval;
        if (!w_q) begin
          if (w_syn != 6'd0) begin
            w_unc     = 1'b1;
            w_err_set = 1'b1;
          end
        end else if (w_syn == 6'd0 || w_pow2) begin
          // Only the stored check entry is bad; memory is intact
          w_store_we = 1'b1;
          w_corr     = 1'b1;
          w_err_set  = 1'b1;
        end else if (w_syn <= 6'd38) begin
          w_state_nxt = S_FIX;
          w_idx_nxt   = r_idx;
          w_we_nxt    = 1'b1;
          w_wdata_nxt = mem_rdata ^ flip_mask(w_syn);
        end else begin
          w_unc     = 1'b1;
          w_err_set = 1'b1;
        end
      end
      S_FIX: begin
        w_store_we  = 1'b1;
        w_store_wd  = w_fix_code;
        w_corr      = 1'b1;
        w_err_set   = 1'b1;
        w_state_nxt = S_WAIT;
        w_idx_nxt   = w_idx_inc;
        w_cnt_nxt   = c_interval;
      end
      default: w_state_nxt = S_INIT;
    endcase
    if (init_req) begin
      w_state_nxt = S_INIT;
      w_idx_nxt   = '0;
      w_store_we  = 1'b0;
      w_corr      = 1'b0;
      w_unc       = 1'b0;
      w_err_set   = 1'b0;
      w_we_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      r_cnt         <= '0;
      for (int i = 0; i < WORDS; i++) r_store[i] <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      busy          <= 1'b1;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      err_addr      <= '0;
      corr_count    <= '0;
      uncorr_count  <= '0;
    end else begin
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      if (w_store_we) r_store[r_idx] <= w_store_wd;
      mem_we        <= w_we_nxt;
      mem_wdata     <= w_wdata_nxt;
      busy          <= (w_state_nxt == S_INIT);
      corrected     <= w_corr;
      uncorrectable <= w_unc;
      if (w_err_set) err_addr <= mem_addr;
      if (w_corr && corr_count != 16'hFFFF) corr_count <= corr_count + 16'd1;
      if (w_unc && uncorr_count != 16'hFFFF) uncorr_count <= uncorr_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_scrubber.sv
`default_nettype none
// ============================================================================
// tb_inst_mem_scrubber : directed bench with a byte-array instruction memory
// Revision 1.0 - initial release
// ============================================================================
module tb_inst_mem_scrubber;

  logic        clk = 1'b0;
  logic        reset, scrub_en, init_req;
  logic [31:0] mem_addr, mem_rdata, mem_wdata, err_addr;
  logic        mem_we, busy, corrected, uncorrectable;
  logic [15:0] corr_count, uncorr_count;

  logic [7:0]  mem [0:31];
  logic [4:0]  ra;
  logic        poke_en;
  logic [2:0]  poke_idx;
  logic [31:0] poke_val;
  logic [31:0] orig [8];

  int errors = 0;
  int checks = 0;
  int corr_ev = 0, unc_ev = 0, we_ev = 0;

  inst_mem_scrubber #(.WORDS(8), .SCRUB_INTERVAL(4)) dut (
    .clk(clk), .reset(reset), .scrub_en(scrub_en), .init_req(init_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .corrected(corrected),
    .uncorrectable(uncorrectable), .err_addr(err_addr),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  assign ra        = mem_addr[4:0];
  assign mem_rdata = {mem[ra], mem[ra + 5'd1], mem[ra + 5'd2], mem[ra + 5'd3]};

  always @(posedge clk) begin
    if (poke_en) begin
      mem[{poke_idx, 2'b00}]         <= poke_val[31:24];
      mem[{poke_idx, 2'b00} + 5'd1]  <= poke_val[23:16];
      mem[{poke_idx, 2'b00} + 5'd2]  <= poke_val[15:8];
      mem[{poke_idx, 2'b00} + 5'd3]  <= poke_val[7:0];
    end
    if (mem_we) begin
      mem[ra]        <= mem_wdata[31:24];
      mem[ra + 5'd1] <= mem_wdata[23:16];
      mem[ra + 5'd2] <= mem_wdata[15:8];
      mem[ra + 5'd3] <= mem_wdata[7:0];
    end
  end

  always @(negedge clk) begin
    if (corrected)     corr_ev++;
    if (uncorrectable) unc_ev++;
    if (mem_we)        we_ev++;
  end

  function automatic logic [31:0] word(input int i);
    logic [4:0] b;
    b = 5'(i * 4);
    return {mem[b], mem[b + 5'd1], mem[b + 5'd2], mem[b + 5'd3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke_word(input int i, input logic [31:0] v);
    poke_idx = 3'(i);
    poke_val = v;
    poke_en  = 1'b1;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  // sel: 0 = mem_we, 1 = uncorrectable
  task automatic wait_sig(input int sel, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if ((sel == 0 && mem_we) || (sel == 1 && uncorrectable)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int c0, u0, w0;
    c0 = corr_ev; u0 = unc_ev; w0 = we_ev;
    repeat (cycles) @(negedge clk);
    check({tag, "_corr"}, corr_ev - c0, 0);
    check({tag, "_unc"},  unc_ev - u0,  0);
    check({tag, "_we"},   we_ev - w0,   0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   busy, 1);
    check({tag, "_addr"},   mem_addr, 0);
    check({tag, "_we"},     mem_we, 0);
    check({tag, "_wdata"},  mem_wdata, 0);
    check({tag, "_corr"},   corrected, 0);
    check({tag, "_unc"},    uncorrectable, 0);
    check({tag, "_eaddr"},  err_addr, 0);
    check({tag, "_ccnt"},   corr_count, 0);
    check({tag, "_ucnt"},   uncorr_count, 0);
  endtask

  initial begin
    int   n, w0;
    logic ok;
    orig[0] = 32'h1234_5678; orig[1] = 32'hDEAD_BEEF;
    orig[2] = 32'hCAFE_F00D; orig[3] = 32'h0BAD_C0DE;
    orig[4] = 32'h0000_0000; orig[5] = 32'hFFFF_FFFF;
    orig[6] = 32'hA5A5_5A5A; orig[7] = 32'h1357_9BDF;
    reset = 1'b1; scrub_en = 1'b1; init_req = 1'b0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) poke_word(i, orig[i]);
    check_reset_outputs("rst");

    reset = 1'b0;
    count_busy(n);
    check("init_cycles", n, 8);
    quiet_window("clean3", 120);

    // word 0, d0 flipped: syndrome 3
    poke_word(0, orig[0] ^ 32'h0000_0001);
    wait_sig(0, 60, ok);
    check("fix0_seen", ok, 1);
    check("fix0_addr", mem_addr, 32'h0);
    check("fix0_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    check("fix0_pulse", corrected, 1);
    check("fix0_ccnt", corr_count, 1);
    check("fix0_eaddr", err_addr, 32'h0);
    check("fix0_we_off", mem_we, 0);
    check("fix0_mem", word(0), 32'h1234_5678);
    @(negedge clk);
    check("fix0_pulse_end", corrected, 0);

    // word 1, d11 and d0 flipped: double error
    w0 = we_ev;
    poke_word(1, orig[1] ^ 32'h0000_0801);
    wait_sig(1, 60, ok);
    check("dbl_seen", ok, 1);
    check("dbl_ucnt1", uncorr_count, 1);
    check("dbl_eaddr", err_addr, 32'h4);
    check("dbl_ccnt", corr_count, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uncorrectable && n < 100);
    check("dbl_period", n, 40);
    check("dbl_ucnt2", uncorr_count, 2);
    check("dbl_mem", word(1), 32'hDEAD_B6EE);
    check("dbl_no_we", we_ev - w0, 0);
    poke_word(1, orig[1]);

    // pause, flip word 3 d15, resume
    scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    poke_word(3, orig[3] ^ 32'h0000_8000);
    quiet_window("paused", 100);
    scrub_en = 1'b1;
    wait_sig(0, 52, ok);
    check("fix3_seen", ok, 1);
    check("fix3_addr", mem_addr, 32'd12);
    check("fix3_wdata", mem_wdata, 32'h0BAD_C0DE);
    @(negedge clk);
    check("fix3_pulse", corrected, 1);
    check("fix3_ccnt", corr_count, 2);
    check("fix3_eaddr", err_addr, 32'd12);

    // reset during FIX of word 5
    poke_word(5, orig[5] ^ 32'h0000_0001);
    wait_sig(0, 60, ok);
    check("fix5_seen", ok, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midfix");
    @(negedge clk);
    @(negedge clk);
    check("midfix_mem", word(5), 32'hFFFF_FFFE);
    reset = 1'b0;
    count_busy(n);
    check("reinit_cycles", n, 8);
    quiet_window("reinit", 90);

    // loader rewrites word 2 with init_req in the same cycle
    init_req = 1'b1;
    poke_word(2, 32'h55AA_33CC);
    init_req = 1'b0;
    count_busy(n);
    check("ireq_cycles", n, 8);
    quiet_window("ireq", 90);
    check("ireq_eaddr", err_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
